// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth signed multiplier with start/done handshake.
// Optional macro BOOTH_ZERO_SKIP_EN: a zero operand bypasses RUN and finishes in one cycle.
module booth_mult_seq #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   multiplicand,
    input  logic [W-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(W);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [W:0]    acc;
    logic [W:0]    mr;
    logic [W-1:0]  qr;
    logic          q_m1;
    logic [CW-1:0] cnt;

    logic          add_op;
    logic          sub_op;
    logic [W:0]    operand_b;
    logic [W:0]    sum;
    logic          carry;
    logic [W:0]    step;
    logic [W:0]    acc_sh;
    logic [W-1:0]  qr_sh;
    logic [CW-1:0] cnt_next;
    logic          skip;

`ifdef BOOTH_ZERO_SKIP_EN
    assign skip = (multiplicand == '0) || (multiplier == '0);
`else
    assign skip = 1'b0;
`endif

    // Subtraction reuses the adder as ACC + ~MR + 1, with the +1 entering as carry-in.
    always_comb begin
        add_op    = ({qr[0], q_m1} == 2'b01);
        sub_op    = ({qr[0], q_m1} == 2'b10);
        operand_b = sub_op ? ~mr : mr;
        sum       = '0;
        carry     = sub_op;
        for (int i = 0; i <= W; i++) begin
            sum[i] = acc[i] ^ operand_b[i] ^ carry;
            carry  = (acc[i] & operand_b[i]) | (carry & (acc[i] ^ operand_b[i]));
        end
        step     = (add_op || sub_op) ? sum : acc;
        acc_sh   = {step[W], step[W:1]};
        qr_sh    = {step[0], qr[W-1:1]};
        cnt_next = cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            mr      <= '0;
            qr      <= '0;
            q_m1    <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && skip) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        product <= '0;
                    end else if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        acc   <= '0;
                        mr    <= {multiplicand[W-1], multiplicand};
                        qr    <= multiplier;
                        q_m1  <= 1'b0;
                        cnt   <= CNT_INIT;
                    end
                end
                RUN: begin
                    acc  <= acc_sh;
                    qr   <= qr_sh;
                    q_m1 <= qr[0];
                    cnt  <= cnt_next;
                    if (cnt_next == '0) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= {acc_sh[W-1:0], qr_sh};
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: vector table, handshake corner cases and
// randomized operands against a plain signed-multiply reference.
module tb_booth_mult_seq;

    localparam int W = 4;

`ifdef BOOTH_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int vecCount;
    int missCount;

    typedef struct {
        logic [W-1:0]   m;
        logic [W-1:0]   q;
        logic [2*W-1:0] exp;
    } vector_t;

    vector_t vectors[8];

    booth_mult_seq #(.W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] refMult(input logic [W-1:0] m, input logic [W-1:0] q);
        longint p;
        p = longint'($signed(m)) * longint'($signed(q));
        return p[2*W-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Issue one multiply from IDLE, return product, edges until done and busy-high samples.
    task automatic applyStimulus(input logic [W-1:0] m, input logic [W-1:0] q,
                                 output logic [2*W-1:0] p, output int lat, output int busyCycles);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = $urandom_range(0, 15);
        multiplier   = $urandom_range(0, 15);
        lat          = 0;
        busyCycles   = 0;
        while (!done && lat < 3 * W + 10) begin
            busyCycles += int'(busy);
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL done_timeout: got no done, expected done within %0d edges", 3 * W + 10);
        end
        checkOutput("busy_during_done", busy, 1'b0);
        p = product;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2*W-1:0] p;
        int lat;
        int busyCycles;
        int expLat;
        int cyc;
        int nDone;
        int doneAt[3];

        vecCount     = 0;
        missCount    = 0;
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        vectors[0] = '{4'h3, 4'h5, 8'h0F};
        vectors[1] = '{4'hD, 4'h5, 8'hF1};
        vectors[2] = '{4'h7, 4'h8, 8'hC8};
        vectors[3] = '{4'h8, 4'h8, 8'h40};
        vectors[4] = '{4'h8, 4'h1, 8'hF8};
        vectors[5] = '{4'h0, 4'hB, 8'h00};
        vectors[6] = '{4'hF, 4'hF, 8'h01};
        vectors[7] = '{4'h7, 4'h7, 8'h31};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_product", product, '0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vectors[i].m, vectors[i].q, p, lat, busyCycles);
            expLat = (ZERO_SKIP && (vectors[i].m == '0 || vectors[i].q == '0)) ? 0 : W;
            checkOutput($sformatf("table_product_%0d", i), p, vectors[i].exp);
            checkOutput($sformatf("table_model_%0d", i), p, refMult(vectors[i].m, vectors[i].q));
            checkOutput($sformatf("table_latency_%0d", i), lat, expLat);
            checkOutput($sformatf("table_busy_cycles_%0d", i), busyCycles, expLat);
        end

        // A start pulse during RUN must be ignored and must not spawn a second operation.
        start        = 1'b1;
        multiplicand = 4'h3;
        multiplier   = 4'h5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start        = 1'b1;
        multiplicand = 4'h2;
        multiplier   = 4'h2;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        while (!done && cyc < 3 * W) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("ignored_start_product", product, 8'h0F);
        nDone = 0;
        repeat (W + 4) begin
            @(posedge clk);
            #1;
            nDone += int'(done);
        end
        checkOutput("ignored_start_no_second_done", nDone, 0);

        // Held start: one result every W+2 cycles.
        start        = 1'b1;
        multiplicand = 4'hD;
        multiplier   = 4'h7;
        nDone        = 0;
        cyc          = 0;
        while (nDone < 3 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                doneAt[nDone] = cyc;
                nDone++;
                checkOutput("b2b_product", product, 8'hEB);
            end
        end
        start = 1'b0;
        checkOutput("b2b_done_count", nDone, 3);
        checkOutput("b2b_interval_1", doneAt[1] - doneAt[0], W + 2);
        checkOutput("b2b_interval_2", doneAt[2] - doneAt[1], W + 2);
        repeat (W + 4) @(posedge clk);
        #1;

        // Reset mid-RUN with cnt=2 aborts without a done.
        checkOutput("pre_abort_product_nonzero", (product != '0), 1'b1);
        start        = 1'b1;
        multiplicand = 4'h6;
        multiplier   = 4'h3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_done", done, 1'b0);
        checkOutput("abort_product", product, '0);
        nDone = 0;
        repeat (W + 4) begin
            @(posedge clk);
            #1;
            nDone += int'(done);
        end
        checkOutput("abort_no_done", nDone, 0);
        applyStimulus(4'h5, 4'hA, p, lat, busyCycles);
        checkOutput("after_abort_product", p, 8'hE2);
        checkOutput("after_abort_latency", lat, W);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] m;
            logic [W-1:0] q;
            m = W'($urandom_range(0, 15));
            q = W'($urandom_range(0, 15));
            applyStimulus(m, q, p, lat, busyCycles);
            expLat = (ZERO_SKIP && (m == '0 || q == '0)) ? 0 : W;
            checkOutput($sformatf("rand_product_%0h_x_%0h", m, q), p, refMult(m, q));
            checkOutput($sformatf("rand_latency_%0h_x_%0h", m, q), lat, expLat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
